// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and the NOP filler word.
// No logic; constants only.
// Imported by if_fetch_ctrl and if_skid_buf.
package cpu_pkg;

  localparam int PC_W = 30;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Fetch FSM encoding (kept as plain constants for legacy tooling).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched {instr, pc4} pair with a full flag.
// Ports: CLK/Reset; load writes d_*, unload empties; full and q_* show the entry.
// Load wins if load and unload coincide (never happens from the fetch FSM).
module if_skid_buf
  import cpu_pkg::*;
(
  input  logic            CLK,
  input  logic            Reset,
  input  logic            load,
  input  logic            unload,
  input  logic [31:0]     d_instr,
  input  logic [PC_W-1:0] d_pc4,
  output logic            full,
  output logic [31:0]     q_instr,
  output logic [PC_W-1:0] q_pc4
);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      full    <= 1'b0;
      q_instr <= NOP_WORD;
      q_pc4   <= '0;
    end else if (load) begin
      full    <= 1'b1;
      q_instr <= d_instr;
      q_pc4   <= d_pc4;
    end else if (unload) begin
      full    <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues req/ack fetches at PC, captures the word
// into an output slot for decode, and pulses PCWre once per capture or flush.
// Ports: CLK/Reset, PC/PCWre to the PC register, imem_* memory handshake,
// id_stall/flush from downstream, if_valid/if_instr/if_pc4 to decode.
module if_fetch_ctrl
  import cpu_pkg::*;
(
  input  logic            CLK,
  input  logic            Reset,
  input  logic [PC_W-1:0] PC,
  output logic            PCWre,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            id_stall,
  input  logic            flush,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [PC_W-1:0] if_pc4
);

  logic [1:0]      state;
  logic [31:0]     slot_instr;
  logic [PC_W-1:0] slot_pc4;

  logic            skid_full;
  logic [31:0]     skid_instr;
  logic [PC_W-1:0] skid_pc4;
  logic            skid_load;
  logic            skid_unload;

  // An ack only means something while a request is actually outstanding.
  logic ack_v;
  logic consume;
  logic can_capture;

  assign ack_v       = imem_req && imem_ack;
  assign consume     = if_valid && !id_stall;
  assign can_capture = !if_valid || !id_stall;

  // Invalid slot presents a clean NOP/0 to decode.
  assign if_instr = if_valid ? slot_instr : NOP_WORD;
  assign if_pc4   = if_valid ? slot_pc4   : '0;

  always_comb begin
    PCWre = 1'b0;
    if (Reset)
      PCWre = 1'b0;
    else if (flush)
      PCWre = 1'b1;
    else if (state == ST_REQ && ack_v)
      PCWre = 1'b1;
  end

  always_comb begin
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    if (!Reset) begin
      if (flush)
        skid_unload = 1'b1;
      else if (state == ST_REQ && ack_v && !can_capture)
        skid_load = 1'b1;
      else if (state == ST_HOLD && !id_stall)
        skid_unload = 1'b1;
    end
  end

  if_skid_buf u_skid (
    .CLK     (CLK),
    .Reset   (Reset),
    .load    (skid_load),
    .unload  (skid_unload),
    .d_instr (imem_rdata),
    .d_pc4   (imem_addr + 30'd1),
    .full    (skid_full),
    .q_instr (skid_instr),
    .q_pc4   (skid_pc4)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= ST_IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      if_valid   <= 1'b0;
      slot_instr <= NOP_WORD;
      slot_pc4   <= '0;
    end else if (flush) begin
      if_valid <= 1'b0;
      case (state)
        // An un-acked request cannot be withdrawn; wait it out in DRAIN.
        ST_REQ, ST_DRAIN: begin
          if (ack_v) begin
            state    <= ST_IDLE;
            imem_req <= 1'b0;
          end else begin
            state    <= ST_DRAIN;
          end
        end
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end else begin
      case (state)
        ST_IDLE: begin
          if (consume) if_valid <= 1'b0;
          if (!skid_full) begin
            state     <= ST_REQ;
            imem_req  <= 1'b1;
            imem_addr <= PC;
          end
        end
        ST_REQ: begin
          if (ack_v) begin
            imem_req <= 1'b0;
            if (can_capture) begin
              if_valid   <= 1'b1;
              slot_instr <= imem_rdata;
              slot_pc4   <= imem_addr + 30'd1;
              state      <= ST_IDLE;
            end else begin
              state      <= ST_HOLD;
            end
          end else if (consume) begin
            if_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          // Slot is stalled-valid here; refill it the edge it is consumed.
          if (!id_stall) begin
            if_valid   <= 1'b1;
            slot_instr <= skid_instr;
            slot_pc4   <= skid_pc4;
            state      <= ST_IDLE;
          end
        end
        default: begin
          if (consume) if_valid <= 1'b0;
          if (ack_v) begin
            imem_req <= 1'b0;
            state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [29:0] PC;
  logic        PCWre;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [29:0] if_pc4;

  int checks = 0;
  int errors = 0;

  if_fetch_ctrl dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .PC         (PC),
    .PCWre      (PCWre),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_stall   (id_stall),
    .flush      (flush),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc4     (if_pc4)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and outputs
  // sampled mid-cycle.
  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [31:0] i, input logic [29:0] p);
    chk({tag, "_valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, "_instr"}, if_instr, i);
    chk({tag, "_pc4"},   {2'd0, if_pc4}, {2'd0, p});
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [29:0] a);
    chk({tag, "_req"},  {31'd0, imem_req}, {31'd0, r});
    chk({tag, "_addr"}, {2'd0, imem_addr}, {2'd0, a});
  endtask

  task automatic chk_pcwre(input string tag, input logic e);
    chk({tag, "_pcwre"}, {31'd0, PCWre}, {31'd0, e});
  endtask

  initial begin
    Reset = 1'b1; PC = 30'h0000_0C00; imem_ack = 1'b0; imem_rdata = '0;
    id_stall = 1'b0; flush = 1'b0;

    // Reset state.
    cyc; settle;
    chk_req("rst", 1'b0, 30'h0);
    chk_slot("rst", 1'b0, 32'h0, 30'h0);
    chk_pcwre("rst", 1'b0);
    Reset = 1'b0;

    // 1: zero-wait memory, one instruction every two cycles.
    cyc; imem_ack = 1'b1; imem_rdata = 32'h1111_1111; settle;
    chk_req("t1a", 1'b1, 30'h0C00);
    chk_pcwre("t1a", 1'b1);
    cyc; imem_ack = 1'b0; PC = 30'h0C01; settle;
    chk_slot("t1a", 1'b1, 32'h1111_1111, 30'h0C01);
    chk_req("t1a_idle", 1'b0, 30'h0C00);
    chk_pcwre("t1a_idle", 1'b0);
    cyc; imem_ack = 1'b1; imem_rdata = 32'h2222_2222; settle;
    chk_req("t1b", 1'b1, 30'h0C01);
    chk({"t1b_consumed"}, {31'd0, if_valid}, 32'd0);
    chk_pcwre("t1b", 1'b1);
    cyc; imem_ack = 1'b0; PC = 30'h0C02; settle;
    chk_slot("t1b", 1'b1, 32'h2222_2222, 30'h0C02);

    // 2: three-cycle ack latency.
    cyc; settle;
    chk_req("t2c1", 1'b1, 30'h0C02);
    chk_pcwre("t2c1", 1'b0);
    cyc; settle;
    chk_req("t2c2", 1'b1, 30'h0C02);
    chk_pcwre("t2c2", 1'b0);
    cyc; imem_ack = 1'b1; imem_rdata = 32'h3333_3333; settle;
    chk_req("t2c3", 1'b1, 30'h0C02);
    chk_pcwre("t2c3", 1'b1);
    cyc; imem_ack = 1'b0; PC = 30'h0C03; settle;
    chk_slot("t2", 1'b1, 32'h3333_3333, 30'h0C03);
    chk_req("t2_done", 1'b0, 30'h0C02);

    // 3: stall with a valid slot, ack goes to skid, release.
    id_stall = 1'b1;
    cyc; imem_ack = 1'b1; imem_rdata = 32'h4444_4444; settle;
    chk_req("t3", 1'b1, 30'h0C03);
    chk_slot("t3_hold", 1'b1, 32'h3333_3333, 30'h0C03);
    chk_pcwre("t3_skid", 1'b1);
    cyc; imem_ack = 1'b0; PC = 30'h0C04; settle;
    chk_req("t3_hold1", 1'b0, 30'h0C03);
    chk_slot("t3_hold1", 1'b1, 32'h3333_3333, 30'h0C03);
    chk_pcwre("t3_hold1", 1'b0);
    cyc; settle;
    chk_req("t3_hold2", 1'b0, 30'h0C03);
    chk_pcwre("t3_hold2", 1'b0);
    id_stall = 1'b0;
    cyc; settle;
    chk_slot("t3_rel", 1'b1, 32'h4444_4444, 30'h0C04);
    chk_req("t3_rel", 1'b0, 30'h0C03);

    // 4: flush while a request is outstanding.
    cyc; flush = 1'b1; settle;
    chk_req("t4", 1'b1, 30'h0C04);
    chk({"t4_consumed"}, {31'd0, if_valid}, 32'd0);
    chk_pcwre("t4_flush", 1'b1);
    cyc; flush = 1'b0; PC = 30'h0D00; settle;
    chk_req("t4_drain", 1'b1, 30'h0C04);
    chk_slot("t4_drain", 1'b0, 32'h0, 30'h0);
    chk_pcwre("t4_drain", 1'b0);
    cyc; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; settle;
    chk_pcwre("t4_drack", 1'b0);
    cyc; imem_ack = 1'b0; settle;
    chk_slot("t4_disc", 1'b0, 32'h0, 30'h0);
    chk_req("t4_idle", 1'b0, 30'h0C04);
    cyc; settle;
    chk_req("t4_new", 1'b1, 30'h0D00);

    // 5: flush coincident with ack.
    imem_ack = 1'b1; imem_rdata = 32'h5555_5555; flush = 1'b1; settle;
    chk_pcwre("t5", 1'b1);
    cyc; imem_ack = 1'b0; flush = 1'b0; settle;
    chk_slot("t5", 1'b0, 32'h0, 30'h0);
    chk_req("t5", 1'b0, 30'h0D00);
    chk_pcwre("t5_after", 1'b0);
    cyc; settle;
    chk_req("t5_new", 1'b1, 30'h0D00);

    // 6: reset mid-request, then a stray ack.
    Reset = 1'b1; settle;
    chk_pcwre("t6_rst", 1'b0);
    cyc; Reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; settle;
    chk_req("t6_rst", 1'b0, 30'h0);
    chk_slot("t6_rst", 1'b0, 32'h0, 30'h0);
    chk_pcwre("t6_stray", 1'b0);
    cyc; imem_ack = 1'b0; settle;
    chk_slot("t6_ign", 1'b0, 32'h0, 30'h0);
    chk_req("t6_restart", 1'b1, 30'h0D00);
    imem_ack = 1'b1; imem_rdata = 32'h6666_6666;
    cyc; imem_ack = 1'b0; PC = 30'h3FFF_FFFF; settle;
    chk_slot("t6_cap", 1'b1, 32'h6666_6666, 30'h0D01);

    // if_pc4 wraps at the top of the word-address space.
    cyc; imem_ack = 1'b1; imem_rdata = 32'h7777_7777; settle;
    chk_req("wrap", 1'b1, 30'h3FFF_FFFF);
    cyc; imem_ack = 1'b0; settle;
    chk_slot("wrap", 1'b1, 32'h7777_7777, 30'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
